cfu_issue_unit: RTL and testbench
=================================

// Module: cfu_issue_unit
// PURPOSE
//  Core-side initiator for the CFU request/response protocol. Accepts CFU instructions from the
//  issue stage and drives them to an attached CFU as requests with stable handshakes.
//  Tracks outstanding requests with a credit counter and buffers CFU responses in an in-order FIFO.
//  Presents those responses to writeback.
//  Flags protocol faults: response timeout and spurious response.
// PARAMETERS
//  ID_W            4     width of instruction/request ID
//  MAX_OUTSTANDING 4     max requests in flight + buffered responses; power of 2, >=2; also resp FIFO depth
//  TIMEOUT_CYCLES  1024  cycles without a response while requests are outstanding before timeout_err
// PORTS
//  clk              in  1      clock, all state on rising edge
//  rst              in  1      asynchronous, active-high reset
//  issue_valid      in  1      issue stage presents a CFU instruction
//  issue_ready      out 1      unit accepts instruction this cycle
//  issue_id         in  ID_W   instruction ID
//  issue_func       in  10     {funct7,funct3} opcode select
//  issue_rs1        in  32     operand 0
//  issue_rs2        in  32     operand 1
//  cfu_req_valid    out 1      request to CFU
//  cfu_req_ready    in  1      CFU accepts request
//  cfu_req_id       out ID_W   request ID
//  cfu_req_func     out 10     function select
//  cfu_req_data0    out 32     operand 0
//  cfu_req_data1    out 32     operand 1
//  cfu_resp_valid   in  1      CFU response valid
//  cfu_resp_ready   out 1      unit accepts response
//  cfu_resp_id      in  ID_W   response ID
//  cfu_resp_data    in  32     result
//  cfu_resp_status  in  3      0 = ok, nonzero = CFU error
//  wb_valid         out 1      result available to writeback
//  wb_ack           in  1      writeback consumes result
//  wb_id            out ID_W   result ID
//  wb_data          out 32     result data
//  wb_err           out 1      cfu_resp_status of entry was nonzero
//  timeout_err      out 1      sticky: response timeout occurred
//  spurious_err     out 1      sticky: response arrived with zero outstanding
// BEHAVIOUR
//  Reset (async, rst=1)
//   - Outputs forced to 0 immediately: cfu_req_valid, wb_valid, timeout_err, spurious_err.
//   - Internal state cleared: credit count=0, FIFO pointers=0, watchdog=0.
//   - cfu_req_* data fields are don't-care.
//  Request stage: one register, states IDLE/PENDING
//   - issue_ready = (IDLE | (cfu_req_valid & cfu_req_ready)) & (credits_used < MAX_OUTSTANDING).
//   - issue handshake loads {id,func,rs1,rs2}; cfu_req_valid=1 next cycle (1-cycle latency).
//   - PENDING & ~cfu_req_ready: all cfu_req_* outputs held stable. No retraction.
//   - Back-to-back: a req handshake with simultaneous issue handshake reloads; stays PENDING.
//  Credits
//   - credits_used counts requests in the register, in flight at the CFU, or held in the FIFO.
//   - +1 on issue handshake; -1 on wb handshake; both in the same cycle => unchanged.
//   - Range 0..MAX_OUTSTANDING; never wraps.
//  Response FIFO
//   - Depth MAX_OUTSTANDING, circular buffer, pointers wrap modulo depth.
//   - cfu_resp_ready = ~full. Under credits, full with resp_valid is unreachable; the bench asserts this.
//   - Push on resp handshake; wb_valid asserts the cycle after push. No bypass.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - wb_err = (status != 0). wb_* are stable while wb_valid & ~wb_ack.
//   - Responses are returned in arrival order; IDs pass through unchecked.
//  Spurious response
//   - Condition: resp handshake while (credits_used - fifo_count) == 0.
//   - Response is dropped, not pushed. spurious_err set (sticky until rst).
//  Watchdog
//   - Counts while in-flight count (credits_used - fifo_count - req PENDING) > 0 and no resp handshake.
//   - Clears to 0 on a resp handshake or when the in-flight count is 0.
//   - At TIMEOUT_CYCLES: timeout_err set (sticky), counter saturates. Traffic is not blocked.
//  Reset mid-operation
//   - All in-flight work is discarded.
//   - CFU responses arriving after reset are treated as spurious.
// TESTING
//  1. Single op: issue id=3 rs1=5 rs2=7 -> cfu_req_valid next cycle with those values.
//     CFU responds data=0xA -> wb_valid 1 cycle later, wb_id=3, wb_data=0xA, wb_err=0.
//  2. Backpressure: hold cfu_req_ready=0 for 5 cycles -> cfu_req_* constant; issue_ready=0.
//     On ready, exactly one handshake.
//  3. Credit limit: MAX_OUTSTANDING=4, wb_ack=0, CFU answers all -> 4 issues accepted.
//     issue_ready=0 thereafter; one wb_ack -> issue_ready=1 next cycle.
//  4. FIFO wrap: stream 10 ops with wb_ack toggling every other cycle -> wb_ids 0..9 in order.
//     No loss, no duplicates.
//  5. Faults: response with status=2 -> wb_err=1.
//     Response with nothing in flight -> dropped, spurious_err=1.
//     Withhold response TIMEOUT_CYCLES -> timeout_err=1.
//  6. Async reset with 3 outstanding -> wb_valid=0 and cfu_req_valid=0 without waiting for a clock edge.
//     After reset, issue_ready=1.

Source files
------------

// File: rtl/cfu_issue_unit.sv
// Core-side CFU initiator: a single request register toward the CFU, credit-based flow control,
// an in-order response FIFO toward writeback, and sticky timeout / spurious-response flags.
module cfu_issue_unit #(
  parameter int unsigned ID_W            = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [9:0]      issue_func_i,
  input  logic [31:0]     issue_rs1_i,
  input  logic [31:0]     issue_rs2_i,
  output logic            cfu_req_valid_o,
  input  logic            cfu_req_ready_i,
  output logic [ID_W-1:0] cfu_req_id_o,
  output logic [9:0]      cfu_req_func_o,
  output logic [31:0]     cfu_req_data0_o,
  output logic [31:0]     cfu_req_data1_o,
  input  logic            cfu_resp_valid_i,
  output logic            cfu_resp_ready_o,
  input  logic [ID_W-1:0] cfu_resp_id_i,
  input  logic [31:0]     cfu_resp_data_i,
  input  logic [2:0]      cfu_resp_status_i,
  output logic            wb_valid_o,
  input  logic            wb_ack_i,
  output logic [ID_W-1:0] wb_id_o,
  output logic [31:0]     wb_data_o,
  output logic            wb_err_o,
  output logic            timeout_err_o,
  output logic            spurious_err_o
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned EntW = ID_W + 33;

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [WdW-1:0]  WdMax  = WdW'(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0]  WdOne  = WdW'(1);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StPending = 1'b1;

  logic [0:0]      req_state_q, req_state_d;
  logic [ID_W-1:0] req_id_q;
  logic [9:0]      req_func_q;
  logic [31:0]     req_data0_q, req_data1_q;
  logic [CntW-1:0] credits_q, credits_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            timeout_err_q, spurious_err_q;
  logic [EntW-1:0] mem_q [MAX_OUTSTANDING];

  logic            req_pending, req_hs, issue_hs, resp_hs, wb_hs;
  logic            spurious, push, full;
  logic [CntW-1:0] inflight;

  assign req_pending   = (req_state_q == StPending);
  assign req_hs        = req_pending & cfu_req_ready_i;
  assign issue_ready_o = (~req_pending | req_hs) & (credits_q < MaxCnt);
  assign issue_hs      = issue_valid_i & issue_ready_o;

  assign full             = (count_q == MaxCnt);
  assign cfu_resp_ready_o = ~full;
  assign resp_hs          = cfu_resp_valid_i & cfu_resp_ready_o;
  // Nothing expected back from the CFU: the response cannot belong to any issued request.
  assign spurious         = resp_hs & (credits_q == count_q);
  assign push             = resp_hs & ~spurious;

  assign wb_valid_o = (count_q != '0);
  assign wb_hs      = wb_valid_o & wb_ack_i;

  // Requests actually handed to the CFU and still awaiting their response.
  assign inflight = credits_q - count_q - CntW'(req_pending);

  always_comb begin
    req_state_d = req_state_q;
    if (issue_hs) begin
      req_state_d = StPending;
    end else if (req_hs) begin
      req_state_d = StIdle;
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (issue_hs && !wb_hs) begin
      credits_d = credits_q + CntOne;
    end else if (!issue_hs && wb_hs) begin
      credits_d = credits_q - CntOne;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !wb_hs) begin
      count_d = count_q + CntOne;
    end else if (!push && wb_hs) begin
      count_d = count_q - CntOne;
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (resp_hs || (inflight == '0)) begin
      wd_d = '0;
    end else if (wd_q != WdMax) begin
      wd_d = wd_q + WdOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_state_q    <= StIdle;
      credits_q      <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wd_q           <= '0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
    end else begin
      req_state_q    <= req_state_d;
      credits_q      <= credits_d;
      count_q        <= count_d;
      wd_q           <= wd_d;
      timeout_err_q  <= timeout_err_q | (wd_q == WdMax);
      spurious_err_q <= spurious_err_q | spurious;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (wb_hs) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the state above.
  always_ff @(posedge clk_i) begin
    if (issue_hs) begin
      req_id_q    <= issue_id_i;
      req_func_q  <= issue_func_i;
      req_data0_q <= issue_rs1_i;
      req_data1_q <= issue_rs2_i;
    end
    if (push) begin
      mem_q[wr_ptr_q] <= {cfu_resp_id_i, cfu_resp_data_i, |cfu_resp_status_i};
    end
  end

  assign cfu_req_valid_o = req_pending;
  assign cfu_req_id_o    = req_id_q;
  assign cfu_req_func_o  = req_func_q;
  assign cfu_req_data0_o = req_data0_q;
  assign cfu_req_data1_o = req_data1_q;

  assign {wb_id_o, wb_data_o, wb_err_o} = mem_q[rd_ptr_q];

  assign timeout_err_o  = timeout_err_q;
  assign spurious_err_o = spurious_err_q;

endmodule

// File: tb/tb_cfu_issue_unit.sv
// Self-checking bench for cfu_issue_unit: vector table, scoreboard on writeback, and
// hand-written sequences for backpressure, credits, wrap, faults and async reset.
module tb_cfu_issue_unit;

  localparam int unsigned To = 64;

  logic        clk, rst;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_id;
  logic [9:0]  issue_func;
  logic [31:0] issue_rs1, issue_rs2;
  logic        cfu_req_valid, cfu_req_ready;
  logic [3:0]  cfu_req_id;
  logic [9:0]  cfu_req_func;
  logic [31:0] cfu_req_data0, cfu_req_data1;
  logic        cfu_resp_valid, cfu_resp_ready;
  logic [3:0]  cfu_resp_id;
  logic [31:0] cfu_resp_data;
  logic [2:0]  cfu_resp_status;
  logic        wb_valid, wb_ack, wb_err;
  logic [3:0]  wb_id;
  logic [31:0] wb_data;
  logic        timeout_err, spurious_err;

  cfu_issue_unit #(.ID_W(4), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(To)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_id_i(issue_id),
    .issue_func_i(issue_func), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .cfu_req_valid_o(cfu_req_valid), .cfu_req_ready_i(cfu_req_ready),
    .cfu_req_id_o(cfu_req_id), .cfu_req_func_o(cfu_req_func),
    .cfu_req_data0_o(cfu_req_data0), .cfu_req_data1_o(cfu_req_data1),
    .cfu_resp_valid_i(cfu_resp_valid), .cfu_resp_ready_o(cfu_resp_ready),
    .cfu_resp_id_i(cfu_resp_id), .cfu_resp_data_i(cfu_resp_data),
    .cfu_resp_status_i(cfu_resp_status),
    .wb_valid_o(wb_valid), .wb_ack_i(wb_ack), .wb_id_o(wb_id), .wb_data_o(wb_data),
    .wb_err_o(wb_err), .timeout_err_o(timeout_err), .spurious_err_o(spurious_err)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [9:0]  func;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [2:0]  status;
    logic        exp_err;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   wb_seen = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writeback scoreboard and response-side protocol monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfu_resp_valid) chk("resp_ready_when_valid", cfu_resp_ready, 1);
      if (wb_valid && wb_ack) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got id %0h data %0h expected nothing", wb_id, wb_data);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_id", wb_id, mon_e.id);
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_err", wb_err, mon_e.err);
          wb_seen++;
        end
      end
    end
  end

  task automatic do_issue(input logic [3:0] id, input logic [9:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] d, input logic e);
    int n = 0;
    issue_valid = 1'b1;
    issue_id = id;
    issue_func = f;
    issue_rs1 = a;
    issue_rs2 = b;
    while (!issue_ready && n < 50) begin
      step();
      n++;
    end
    if (!issue_ready) begin
      chk("issue_accept_timeout", issue_ready, 1);
    end else begin
      sb.push_back('{id: id, data: d, err: e});
    end
    step();
    issue_valid = 1'b0;
  endtask

  task automatic resp(input logic [3:0] id, input logic [31:0] d, input logic [2:0] st);
    cfu_resp_valid = 1'b1;
    cfu_resp_id = id;
    cfu_resp_data = d;
    cfu_resp_status = st;
    step();
    cfu_resp_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    wb_ack = 1'b1;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    wb_ack = 1'b0;
    chk("drain_sb_empty", sb.size(), 0);
    @(negedge clk);
    chk("drain_wb_valid", wb_valid, 0);
    step();
  endtask

  task automatic run_vec(input vec_t v);
    do_issue(v.id, v.func, v.rs1, v.rs2, v.rdata, v.exp_err);
    @(negedge clk);
    chk("req_valid", cfu_req_valid, 1);
    chk("req_id", cfu_req_id, v.id);
    chk("req_func", cfu_req_func, v.func);
    chk("req_data0", cfu_req_data0, v.rs1);
    chk("req_data1", cfu_req_data1, v.rs2);
    step();
    cfu_req_ready = 1'b1;
    step();
    cfu_req_ready = 1'b0;
    @(negedge clk);
    chk("req_done", cfu_req_valid, 0);
    step();
    cfu_resp_valid = 1'b1;
    cfu_resp_id = v.id;
    cfu_resp_data = v.rdata;
    cfu_resp_status = v.status;
    @(negedge clk);
    chk("no_bypass", wb_valid, 0);
    step();
    cfu_resp_valid = 1'b0;
    @(negedge clk);
    chk("wb_valid_after_push", wb_valid, 1);
    step();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    @(negedge clk);
    chk("wb_valid_after_ack", wb_valid, 0);
    step();
  endtask

  // Free-running traffic: CFU always ready, answers each request one cycle after accepting it
  // with data0+data1. ack_mode 1 toggles wb_ack every cycle, 0 never acks.
  task automatic stream(input int n, input int ack_mode, input int budget, output int issued);
    logic [3:0]  rq_id[$];
    logic [31:0] rq_data[$];
    int cyc = 0;
    issued = 0;
    cfu_req_ready = 1'b1;
    while (cyc < budget) begin
      issue_valid = (issued < n);
      issue_id = issued[3:0];
      issue_func = 10'h003;
      issue_rs1 = 32'h1000 * issued + 1;
      issue_rs2 = issued * 3;
      cfu_resp_valid = (rq_id.size() > 0);
      if (rq_id.size() > 0) begin
        cfu_resp_id = rq_id[0];
        cfu_resp_data = rq_data[0];
        cfu_resp_status = 3'd0;
      end
      wb_ack = (ack_mode == 1) ? cyc[0] : 1'b0;
      @(negedge clk);
      if (issue_valid && issue_ready) begin
        sb.push_back('{id: issue_id, data: issue_rs1 + issue_rs2, err: 1'b0});
        issued++;
      end
      if (cfu_req_valid && cfu_req_ready) begin
        rq_id.push_back(cfu_req_id);
        rq_data.push_back(cfu_req_data0 + cfu_req_data1);
      end
      if (cfu_resp_valid && cfu_resp_ready) begin
        void'(rq_id.pop_front());
        void'(rq_data.pop_front());
      end
      step();
      cyc++;
      if (issued == n && rq_id.size() == 0 && !cfu_req_valid && (ack_mode == 0 || sb.size() == 0))
        break;
    end
    issue_valid = 1'b0;
    cfu_resp_valid = 1'b0;
    cfu_req_ready = 1'b0;
    wb_ack = 1'b0;
  endtask

  initial begin
    int got;
    int seen0;

    vecs[0] = '{4'd3,  10'h000, 32'd5,        32'd7,        32'h0000_000A, 3'd0, 1'b0};
    vecs[1] = '{4'd15, 10'h3FF, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 3'd0, 1'b0};
    vecs[2] = '{4'd0,  10'h155, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h1234_5678, 3'd2, 1'b1};
    vecs[3] = '{4'd9,  10'h2AA, 32'h8000_0000, 32'h0000_0001, 32'h0,         3'd7, 1'b1};
    vecs[4] = '{4'd6,  10'h081, 32'h0BAD_F00D, 32'hCAFE_BABE, 32'h8000_0001, 3'd1, 1'b1};
    vecs[5] = '{4'd12, 10'h200, 32'h0000_FFFF, 32'hFFFF_0000, 32'h7FFF_FFFF, 3'd0, 1'b0};

    rst = 1'b1;
    issue_valid = 1'b0; issue_id = '0; issue_func = '0; issue_rs1 = '0; issue_rs2 = '0;
    cfu_req_ready = 1'b0;
    cfu_resp_valid = 1'b0; cfu_resp_id = '0; cfu_resp_data = '0; cfu_resp_status = '0;
    wb_ack = 1'b0;
    #3;
    chk("rst_req_valid", cfu_req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_spurious", spurious_err, 0);
    chk("rst_issue_ready", issue_ready, 1);
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure, then a back-to-back reload on the releasing cycle.
    do_issue(4'd5, 10'h2A5, 32'hDEAD_BEEF, 32'h1234_5678, 32'h55, 1'b0);
    issue_valid = 1'b1; issue_id = 4'd6; issue_func = 10'h011; issue_rs1 = 32'd1; issue_rs2 = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", cfu_req_valid, 1);
      chk("bp_id", cfu_req_id, 5);
      chk("bp_func", cfu_req_func, 10'h2A5);
      chk("bp_data0", cfu_req_data0, 32'hDEAD_BEEF);
      chk("bp_data1", cfu_req_data1, 32'h1234_5678);
      chk("bp_issue_ready", issue_ready, 0);
      step();
    end
    cfu_req_ready = 1'b1;
    @(negedge clk);
    chk("b2b_issue_ready", issue_ready, 1);
    step();
    sb.push_back('{id: 4'd6, data: 32'h66, err: 1'b0});
    issue_valid = 1'b0;
    cfu_req_ready = 1'b0;
    @(negedge clk);
    chk("b2b_valid", cfu_req_valid, 1);
    chk("b2b_id", cfu_req_id, 6);
    chk("b2b_data0", cfu_req_data0, 1);
    step();
    cfu_req_ready = 1'b1;
    step();
    cfu_req_ready = 1'b0;
    @(negedge clk);
    chk("b2b_done", cfu_req_valid, 0);
    step();
    resp(4'd5, 32'h55, 3'd0);
    resp(4'd6, 32'h66, 3'd0);
    drain(20);

    // Credit limit with writeback stalled.
    stream(6, 0, 40, got);
    chk("credit_issued", got, 4);
    @(negedge clk);
    chk("credit_issue_ready", issue_ready, 0);
    chk("credit_fifo_full", cfu_resp_ready, 0);
    step();
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    @(negedge clk);
    chk("credit_release", issue_ready, 1);
    step();
    drain(20);

    // FIFO wrap: ten ops, writeback acked every other cycle.
    seen0 = wb_seen;
    stream(10, 1, 400, got);
    chk("wrap_issued", got, 10);
    chk("wrap_seen", wb_seen - seen0, 10);
    chk("wrap_sb_empty", sb.size(), 0);

    // Spurious response with nothing outstanding.
    @(negedge clk);
    chk("pre_spurious", spurious_err, 0);
    step();
    resp(4'd9, 32'hBAD, 3'd0);
    @(negedge clk);
    chk("spurious_set", spurious_err, 1);
    chk("spurious_dropped", wb_valid, 0);
    step();

    // Watchdog: request accepted by the CFU but never answered.
    @(negedge clk);
    chk("pre_timeout", timeout_err, 0);
    step();
    do_issue(4'd7, 10'h001, 32'd1, 32'd1, 32'h77, 1'b0);
    cfu_req_ready = 1'b1;
    step();
    cfu_req_ready = 1'b0;
    repeat (To - 3) step();
    @(negedge clk);
    chk("timeout_early", timeout_err, 0);
    repeat (6) step();
    @(negedge clk);
    chk("timeout_set", timeout_err, 1);
    step();
    resp(4'd7, 32'h77, 3'd0);
    drain(20);
    chk("timeout_sticky", timeout_err, 1);

    // Async reset with three outstanding: one buffered, one at the CFU, one pending.
    do_issue(4'd1, 10'h0, 32'd1, 32'd0, 32'h11, 1'b0);
    cfu_req_ready = 1'b1;
    step();
    cfu_req_ready = 1'b0;
    resp(4'd1, 32'h11, 3'd0);
    do_issue(4'd2, 10'h0, 32'd2, 32'd0, 32'h22, 1'b0);
    cfu_req_ready = 1'b1;
    step();
    cfu_req_ready = 1'b0;
    do_issue(4'd3, 10'h0, 32'd3, 32'd0, 32'h33, 1'b0);
    @(negedge clk);
    chk("prerst_wb_valid", wb_valid, 1);
    chk("prerst_req_valid", cfu_req_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_req_valid", cfu_req_valid, 0);
    chk("arst_timeout", timeout_err, 0);
    chk("arst_spurious", spurious_err, 0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_issue_ready", issue_ready, 1);
    step();
    resp(4'd2, 32'h22, 3'd0);
    @(negedge clk);
    chk("postrst_spurious", spurious_err, 1);
    chk("postrst_wb_valid", wb_valid, 0);
    step();
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
